// File: rtl/dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// dram_port_arbiter : per-burst arbiter sharing one DDR2 user port among
//                     M0 (VGA refill), M1 (CPU) and M2 (SD DMA)
// Rev 1.0
// ============================================================================
module dram_port_arbiter #(
    parameter int AW     = 27,
    parameter int DW     = 32,
    parameter int BW     = 4,
    parameter int HIPRI0 = 1
) (
    input  logic                CLK,
    input  logic                RST_X,
    input  logic [3*AW-1:0]     m_addr,
    input  logic [3*BW-1:0]     m_burst,
    input  logic [3*DW-1:0]     m_wdata,
    input  logic [3*DW/8-1:0]   m_be,
    input  logic [2:0]          m_read,
    input  logic [2:0]          m_write,
    output logic [2:0]          m_wait,
    output logic [2:0]          m_rvalid,
    output logic [DW-1:0]       m_rdata,
    output logic [AW-1:0]       d_addr,
    output logic [BW-1:0]       d_burst,
    output logic [DW-1:0]       d_wdata,
    output logic [DW/8-1:0]     d_be,
    output logic                d_read,
    output logic                d_write,
    input  logic                d_wait,
    input  logic                d_rvalid,
    input  logic [DW-1:0]       d_rdata,
    output logic [2:0]          grant,
    output logic                dram_read,
    output logic                dram_write
);

    localparam int BEW = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR      = 2'd1,
        S_RD_CMD  = 2'd2,
        S_RD_DATA = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_grant;
    logic [1:0]      r_owner;
    logic [1:0]      r_rr;
    logic [BW-1:0]   r_beats;
    logic [BW-1:0]   r_burst;

    logic [AW-1:0]   w_addr  [3];
    logic [BW-1:0]   w_burst [3];
    logic [DW-1:0]   w_wdata [3];
    logic [BEW-1:0]  w_be    [3];

    logic [2:0]      w_req;
    logic [1:0]      w_c0;
    logic [1:0]      w_c1;
    logic [1:0]      w_c2;
    logic [1:0]      w_win;
    logic [2:0]      w_win_oh;
    logic            w_win_wr;
    logic [BW-1:0]   w_win_burst;
    logic            w_wr_g;
    logic            w_load;
    logic            w_dec;
    logic            w_done;

    function automatic logic [1:0] f_inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
            assign w_addr[gi]  = m_addr[gi*AW +: AW];
            assign w_burst[gi] = m_burst[gi*BW +: BW];
            assign w_wdata[gi] = m_wdata[gi*DW +: DW];
            assign w_be[gi]    = m_be[gi*BEW +: BEW];
        end
    endgenerate

    assign w_req = m_read | m_write;

    // Priority order: optional fixed M0, then a rotation starting at r_rr.
    always_comb begin
        w_c0 = r_rr;
        w_c1 = f_inc3(r_rr);
        w_c2 = f_inc3(w_c1);
        if ((HIPRI0 != 0) && w_req[0]) begin
            w_win = 2'd0;
        end else if (w_req[w_c0]) begin
            w_win = w_c0;
        end else if (w_req[w_c1]) begin
            w_win = w_c1;
        end else begin
            w_win = w_c2;
        end
    end

    assign w_win_oh    = 3'b001 << w_win;
    assign w_win_wr    = m_write[w_win];
    assign w_win_burst = (w_burst[w_win] == '0) ? BW'(1) : w_burst[w_win];
    assign w_wr_g      = m_write[r_owner];

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_done      = 1'b0;
        m_wait      = 3'b111;
        m_rvalid    = 3'b000;
        d_read      = 1'b0;
        d_write     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req != 3'b000) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_win_wr ? S_WR : S_RD_CMD;
                end
            end
            S_WR: begin
                d_write          = w_wr_g;
                m_wait[r_owner]  = d_wait;
                if (w_wr_g && !d_wait) begin
                    w_dec = 1'b1;
                    if (r_beats == BW'(1)) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_RD_CMD: begin
                d_read           = 1'b1;
                m_wait[r_owner]  = d_wait;
                if (!d_wait) begin
                    w_state_nxt = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                m_rvalid[r_owner] = d_rvalid;
                if (d_rvalid) begin
                    w_dec = 1'b1;
                    if (r_beats == BW'(1)) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            r_state <= S_IDLE;
            r_grant <= 3'b000;
            r_owner <= 2'd0;
            r_rr    <= 2'd0;
            r_beats <= '0;
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_grant <= w_win_oh;
                r_owner <= w_win;
                r_beats <= w_win_burst;
                r_burst <= w_win_burst;
            end else if (w_dec) begin
                r_beats <= r_beats - BW'(1);
            end
            // Rotation advances only once the winner's burst has fully completed.
            if (w_done) begin
                r_grant <= 3'b000;
                r_rr    <= f_inc3(r_owner);
            end
        end
    end

    // The controller sees the normalised burst length, so a 0 request reads as 1 beat.
    assign d_addr     = w_addr[r_owner];
    assign d_burst    = r_burst;
    assign d_wdata    = w_wdata[r_owner];
    assign d_be       = w_be[r_owner];
    assign m_rdata    = d_rdata;
    assign grant      = r_grant;
    assign dram_read  = (r_state == S_RD_CMD) || (r_state == S_RD_DATA);
    assign dram_write = (r_state == S_WR);

endmodule
`default_nettype wire
